// File: rtl/audio_controller.sv
// audio_controller: streaming interface between user sample logic and the
// WM8731 codec pins. Captures left-justified ADC frames into an input FIFO,
// plays pairs from an output FIFO onto the DAC line and divides CLOCK_50
// by four for the codec master clock. The codec is bit/frame-clock master.
//
// User-side handshake: read_audio_in pops the head pair when
// audio_in_available is 1 (head data is shown ahead and is 0 when empty);
// write_audio_out pushes one pair when audio_out_allowed is 1. A request
// made while its flag is 0 is dropped without side effects. A clear in the
// same cycle wins over a push or pop on that FIFO.
module audio_controller #(
    parameter int AUDIO_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH       = 128
) (
    input  logic                        CLOCK_50,
    input  logic                        reset,
    input  logic                        clear_audio_in_memory,
    input  logic                        read_audio_in,
    input  logic                        clear_audio_out_memory,
    input  logic [AUDIO_DATA_WIDTH-1:0] left_channel_audio_out,
    input  logic [AUDIO_DATA_WIDTH-1:0] right_channel_audio_out,
    input  logic                        write_audio_out,
    input  logic                        AUD_ADCDAT,
    inout  wire                         AUD_BCLK,
    inout  wire                         AUD_ADCLRCK,
    inout  wire                         AUD_DACLRCK,
    output logic                        audio_in_available,
    output logic [AUDIO_DATA_WIDTH-1:0] left_channel_audio_in,
    output logic [AUDIO_DATA_WIDTH-1:0] right_channel_audio_in,
    output logic                        audio_out_allowed,
    output logic                        AUD_XCK,
    output logic                        AUD_DACDAT
);

    localparam int W  = AUDIO_DATA_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(AUDIO_DATA_WIDTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] SLOT_BITS  = BW'(AUDIO_DATA_WIDTH);

    // The codec owns these clocks; we only listen.
    assign AUD_BCLK    = 1'bz;
    assign AUD_ADCLRCK = 1'bz;
    assign AUD_DACLRCK = 1'bz;

    // ------------------------------------------------------------------
    // Pin synchronizers and edge detection
    // ------------------------------------------------------------------
    // Bit order: {adcdat, daclrck, adclrck, bclk}. ADCDAT rides through the
    // same two stages so it stays aligned with the synchronized BCLK.
    logic [3:0] pins;
    logic [3:0] sync_a;
    logic [3:0] sync_b;
    logic [2:0] sync_c;
    logic [1:0] prime_cnt;
    logic       sync_ok;

    assign pins = {AUD_ADCDAT, AUD_DACLRCK, AUD_ADCLRCK, AUD_BCLK};

    // Two-flop synchronizers plus history flop; edges are suppressed until
    // the pipeline holds real pin values so reset release cannot fake an edge.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            sync_a    <= '0;
            sync_b    <= '0;
            sync_c    <= '0;
            prime_cnt <= '0;
        end else begin
            sync_a <= pins;
            sync_b <= sync_a;
            sync_c <= sync_b[2:0];
            if (prime_cnt != 2'd3) prime_cnt <= prime_cnt + 2'd1;
        end
    end

    assign sync_ok = (prime_cnt == 2'd3);

    logic bclk_rise, bclk_fall, adc_rise, adc_fall, dac_rise, dac_fall, adc_bit;

    assign bclk_rise = sync_ok &  sync_b[0] & ~sync_c[0];
    assign bclk_fall = sync_ok & ~sync_b[0] &  sync_c[0];
    assign adc_rise  = sync_ok &  sync_b[1] & ~sync_c[1];
    assign adc_fall  = sync_ok & ~sync_b[1] &  sync_c[1];
    assign dac_rise  = sync_ok &  sync_b[2] & ~sync_c[2];
    assign dac_fall  = sync_ok & ~sync_b[2] &  sync_c[2];
    assign adc_bit   = sync_b[3];

    // ------------------------------------------------------------------
    // Capture path
    // ------------------------------------------------------------------
    logic [W-1:0]  adc_left;
    logic [W-1:0]  adc_right;
    logic [BW-1:0] adc_cnt;
    logic          adc_sel_right;
    logic          left_started;
    logic          right_done;
    logic          frame_push;

    // A frame is handed over on the LRCK rise that follows a full right slot,
    // but only if its left slot started after reset was released.
    assign frame_push = adc_rise & left_started & right_done;

    // Deserialize the current slot; bits beyond the word width are ignored.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            adc_left      <= '0;
            adc_right     <= '0;
            adc_cnt       <= '0;
            adc_sel_right <= 1'b0;
            left_started  <= 1'b0;
            right_done    <= 1'b0;
        end else if (adc_rise) begin
            adc_cnt       <= '0;
            adc_sel_right <= 1'b0;
            left_started  <= 1'b1;
            right_done    <= 1'b0;
        end else if (adc_fall) begin
            adc_cnt       <= '0;
            adc_sel_right <= 1'b1;
            right_done    <= 1'b0;
        end else if (bclk_rise && (adc_cnt < SLOT_BITS)) begin
            if (adc_sel_right) adc_right <= {adc_right[W-2:0], adc_bit};
            else               adc_left  <= {adc_left[W-2:0], adc_bit};
            adc_cnt <= adc_cnt + BW'(1);
            if (adc_sel_right && (adc_cnt == SLOT_BITS - BW'(1))) right_done <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [2*W-1:0] in_mem [FIFO_DEPTH];
    logic [AW-1:0]  in_wr_ptr;
    logic [AW-1:0]  in_rd_ptr;
    logic [CW-1:0]  in_count;
    logic           in_empty, in_full, in_push, in_pop;
    logic [2*W-1:0] in_head;

    assign in_empty = (in_count == '0);
    assign in_full  = (in_count == FULL_COUNT);
    assign in_push  = frame_push & ~in_full & ~clear_audio_in_memory;
    assign in_pop   = read_audio_in & ~in_empty & ~clear_audio_in_memory;

    // Input FIFO pointers and occupancy; a full FIFO drops the new frame.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            in_wr_ptr <= '0;
            in_rd_ptr <= '0;
            in_count  <= '0;
        end else if (clear_audio_in_memory) begin
            in_wr_ptr <= '0;
            in_rd_ptr <= '0;
            in_count  <= '0;
        end else begin
            if (in_push) in_wr_ptr <= in_wr_ptr + AW'(1);
            if (in_pop)  in_rd_ptr <= in_rd_ptr + AW'(1);
            case ({in_push, in_pop})
                2'b10:   in_count <= in_count + CW'(1);
                2'b01:   in_count <= in_count - CW'(1);
                default: in_count <= in_count;
            endcase
        end
    end

    // Input FIFO storage, {left, right} per entry.
    always_ff @(posedge CLOCK_50) begin
        if (in_push) in_mem[in_wr_ptr] <= {adc_left, adc_right};
    end

    assign in_head                = in_mem[in_rd_ptr];
    assign audio_in_available     = ~in_empty;
    assign left_channel_audio_in  = in_empty ? '0 : in_head[2*W-1:W];
    assign right_channel_audio_in = in_empty ? '0 : in_head[W-1:0];

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [2*W-1:0] out_mem [FIFO_DEPTH];
    logic [AW-1:0]  out_wr_ptr;
    logic [AW-1:0]  out_rd_ptr;
    logic [CW-1:0]  out_count;
    logic           out_empty, out_full, out_push, out_pop;

    assign out_empty = (out_count == '0);
    assign out_full  = (out_count == FULL_COUNT);
    assign out_push  = write_audio_out & ~out_full & ~clear_audio_out_memory;
    assign out_pop   = dac_rise & ~out_empty & ~clear_audio_out_memory;

    // Output FIFO pointers and occupancy; the DAC frame start is the consumer.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            out_wr_ptr <= '0;
            out_rd_ptr <= '0;
            out_count  <= '0;
        end else if (clear_audio_out_memory) begin
            out_wr_ptr <= '0;
            out_rd_ptr <= '0;
            out_count  <= '0;
        end else begin
            if (out_push) out_wr_ptr <= out_wr_ptr + AW'(1);
            if (out_pop)  out_rd_ptr <= out_rd_ptr + AW'(1);
            case ({out_push, out_pop})
                2'b10:   out_count <= out_count + CW'(1);
                2'b01:   out_count <= out_count - CW'(1);
                default: out_count <= out_count;
            endcase
        end
    end

    // Output FIFO storage, {left, right} per entry.
    always_ff @(posedge CLOCK_50) begin
        if (out_push) out_mem[out_wr_ptr] <= {left_channel_audio_out, right_channel_audio_out};
    end

    assign audio_out_allowed = ~out_full;

    // ------------------------------------------------------------------
    // Playback path
    // ------------------------------------------------------------------
    logic [W-1:0] dac_left;
    logic [W-1:0] dac_right;
    logic         dac_sel_right;

    // Load a pair (or silence) at frame start and shift the active word one
    // bit per BCLK fall; zero fill makes the line idle at 0 past the word.
    // An LRCK edge shares its instant with a BCLK fall, so it wins and the
    // MSB stays on the line for the first bit period.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            dac_left      <= '0;
            dac_right     <= '0;
            dac_sel_right <= 1'b0;
        end else if (dac_rise) begin
            dac_sel_right <= 1'b0;
            if (out_pop) {dac_left, dac_right} <= out_mem[out_rd_ptr];
            else         {dac_left, dac_right} <= '0;
        end else if (dac_fall) begin
            dac_sel_right <= 1'b1;
        end else if (bclk_fall) begin
            if (dac_sel_right) dac_right <= {dac_right[W-2:0], 1'b0};
            else               dac_left  <= {dac_left[W-2:0], 1'b0};
        end
    end

    assign AUD_DACDAT = dac_sel_right ? dac_right[W-1] : dac_left[W-1];

    // ------------------------------------------------------------------
    // Codec master clock
    // ------------------------------------------------------------------
    logic [1:0] xck_cnt;

    // Free-running divide-by-four of CLOCK_50.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) xck_cnt <= '0;
        else        xck_cnt <= xck_cnt + 2'd1;
    end

    assign AUD_XCK = xck_cnt[1];

endmodule

// File: tb/tb_audio_controller.sv
// tb_audio_controller: directed bench for audio_controller with a small
// codec model (BCLK = CLOCK_50/8, slots two bits longer than the word).
module tb_audio_controller;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int SLOT  = W + 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rst_n;
    logic         clear_in, read_in, clear_out, write_out;
    logic [W-1:0] left_out, right_out;
    logic         bclk_pin, lrck_pin, adcdat_pin;
    wire          aud_bclk, aud_adclrck, aud_daclrck;
    logic         audio_in_available, audio_out_allowed, aud_xck, aud_dacdat;
    logic [W-1:0] left_in, right_in;

    assign aud_bclk    = bclk_pin;
    assign aud_adclrck = lrck_pin;
    assign aud_daclrck = lrck_pin;

    audio_controller #(.AUDIO_DATA_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
        .CLOCK_50               (clk),
        .reset                  (rst_n),
        .clear_audio_in_memory  (clear_in),
        .read_audio_in          (read_in),
        .clear_audio_out_memory (clear_out),
        .left_channel_audio_out (left_out),
        .right_channel_audio_out(right_out),
        .write_audio_out        (write_out),
        .AUD_ADCDAT             (adcdat_pin),
        .AUD_BCLK               (aud_bclk),
        .AUD_ADCLRCK            (aud_adclrck),
        .AUD_DACLRCK            (aud_daclrck),
        .audio_in_available     (audio_in_available),
        .left_channel_audio_in  (left_in),
        .right_channel_audio_in (right_in),
        .audio_out_allowed      (audio_out_allowed),
        .AUD_XCK                (aud_xck),
        .AUD_DACDAT             (aud_dacdat)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- codec model ----------------
    logic [2*W-1:0] adc_q[$];
    int             frame_starts;
    logic [2*W-1:0] last_dac;
    logic           last_tail;

    initial begin : codec_model
        logic [2*W-1:0] cur;
        logic [W-1:0]   cap_l, cap_r;
        logic           tail;
        bclk_pin     = 1'b1;
        lrck_pin     = 1'b0;
        adcdat_pin   = 1'b0;
        frame_starts = 0;
        last_dac     = '0;
        last_tail    = 1'b0;
        forever begin
            cur = (adc_q.size() > 0) ? adc_q.pop_front() : '0;
            cap_l = '0;
            cap_r = '0;
            tail  = 1'b0;
            frame_starts++;
            for (int s = 0; s < 2; s++) begin
                for (int b = 0; b < SLOT; b++) begin
                    bclk_pin = 1'b0;
                    if (b == 0) lrck_pin = (s == 0);
                    if (b < W) adcdat_pin = (s == 0) ? cur[2*W-1-b] : cur[W-1-b];
                    else       adcdat_pin = 1'b1;
                    repeat (4) @(negedge clk);
                    bclk_pin = 1'b1;
                    if (b < W) begin
                        if (s == 0) cap_l[W-1-b] = aud_dacdat;
                        else        cap_r[W-1-b] = aud_dacdat;
                    end else begin
                        tail = tail | aud_dacdat;
                    end
                    repeat (4) @(negedge clk);
                end
            end
            last_dac  = {cap_l, cap_r};
            last_tail = tail;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_frame();
        int start;
        int n;
        start = frame_starts;
        n = 0;
        while (frame_starts == start && n < 1500) begin
            @(negedge clk);
            n++;
        end
        check("frame_timeout", 64'(frame_starts != start), 64'd1);
        repeat (8) @(negedge clk);
    endtask

    task automatic write_pair(input logic [2*W-1:0] p);
        left_out  = p[2*W-1:W];
        right_out = p[W-1:0];
        write_out = 1'b1;
        @(negedge clk);
        write_out = 1'b0;
    endtask

    task automatic pulse_read();
        read_in = 1'b1;
        @(negedge clk);
        read_in = 1'b0;
    endtask

    task automatic check_dac(input string tag, input logic [2*W-1:0] exp);
        check(tag, last_dac, exp);
        check({tag, "_tail"}, 64'(last_tail), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    logic [2*W-1:0] q_vec [5];
    logic [2*W-1:0] p_vec [5];
    logic [2*W-1:0] d_pair, r_bad, r_good;

    initial begin : main_seq
        int rises;
        int rise_t [2];
        logic prev;

        q_vec[0] = {32'h1111_0000, 32'h0000_1111};
        q_vec[1] = {32'h2222_0001, 32'h1000_2222};
        q_vec[2] = {32'h3333_0002, 32'h2000_3333};
        q_vec[3] = {32'h4444_0003, 32'h3000_4444};
        q_vec[4] = {32'hDEAD_BEEF, 32'hCAFE_F00D};
        p_vec[0] = {32'hF0F0_0000, 32'h0F0F_0001};
        p_vec[1] = {32'hFFFF_FFFF, 32'h0000_0001};
        p_vec[2] = {32'h1234_5678, 32'h9ABC_DEF0};
        p_vec[3] = {32'h8000_0000, 32'h0000_0001};
        p_vec[4] = {32'h5555_5555, 32'hAAAA_AAAA};
        d_pair   = {32'h8000_0001, 32'h7FFF_FFFE};
        r_bad    = {32'hBAD0_BAD0, 32'hBAD1_BAD1};
        r_good   = {32'h600D_0001, 32'h600D_0002};

        rst_n = 1'b0;
        clear_in = 1'b0; read_in = 1'b0; clear_out = 1'b0; write_out = 1'b0;
        left_out = '0; right_out = '0;

        // reset state
        repeat (10) @(negedge clk);
        check("rst_available", 64'(audio_in_available), 64'd0);
        check("rst_allowed",   64'(audio_out_allowed),  64'd1);
        check("rst_dacdat",    64'(aud_dacdat),         64'd0);
        check("rst_left_in",   64'(left_in),            64'd0);
        check("rst_right_in",  64'(right_in),           64'd0);
        check("rst_xck",       64'(aud_xck),            64'd0);
        rst_n = 1'b1;

        // master clock period
        rises = 0;
        rise_t[0] = 0;
        rise_t[1] = 0;
        prev = aud_xck;
        for (int i = 0; i < 20 && rises < 2; i++) begin
            @(negedge clk);
            if (aud_xck && !prev) begin
                rise_t[rises] = cyc;
                rises++;
            end
            prev = aud_xck;
        end
        check("xck_period", 64'((rises == 2) ? (rise_t[1] - rise_t[0]) : 0), 64'd4);

        // capture of one frame; the frame running across reset release is ignored
        adc_q.push_back({32'hA5A5_0001, 32'h0000_FFFF});
        wait_frame();
        check("pre_reset_frame_ignored", 64'(audio_in_available), 64'd0);
        wait_frame();
        check("cap_available", 64'(audio_in_available), 64'd1);
        check("cap_left",      64'(left_in),  64'hA5A5_0001);
        check("cap_right",     64'(right_in), 64'h0000_FFFF);
        check_dac("dac_silent_f1", '0);
        pulse_read();
        check("read_available", 64'(audio_in_available), 64'd0);
        check("read_left_zero", 64'(left_in), 64'd0);

        // single playback pair
        write_pair(d_pair);
        check("one_write_allowed", 64'(audio_out_allowed), 64'd1);
        wait_frame();
        check_dac("dac_silent_f2", '0);
        for (int i = 0; i < 5; i++) adc_q.push_back(q_vec[i]);
        wait_frame();
        check_dac("dac_pair", d_pair);

        // flush input FIFO, then fill the output FIFO plus one extra write
        clear_in = 1'b1;
        @(negedge clk);
        clear_in = 1'b0;
        check("clear_in_available", 64'(audio_in_available), 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            write_pair(p_vec[i]);
            check($sformatf("fill_allowed_%0d", i), 64'(audio_out_allowed), 64'(i < DEPTH - 1));
        end
        write_pair(p_vec[4]);
        check("extra_write_allowed", 64'(audio_out_allowed), 64'd0);

        wait_frame();
        check_dac("dac_silent_f4", '0);
        check("pop_allowed", 64'(audio_out_allowed), 64'd1);
        check("q0_head_left", 64'(left_in), 64'(q_vec[0][2*W-1:W]));
        for (int i = 0; i < DEPTH; i++) begin
            wait_frame();
            check_dac($sformatf("dac_fifo_%0d", i), p_vec[i]);
        end

        // input overflow: Q4 must be absent
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("ovf_avail_%0d", i), 64'(audio_in_available), 64'd1);
            check($sformatf("ovf_left_%0d", i),  64'(left_in),  64'(q_vec[i][2*W-1:W]));
            check($sformatf("ovf_right_%0d", i), 64'(right_in), 64'(q_vec[i][W-1:0]));
            pulse_read();
        end
        check("ovf_drained", 64'(audio_in_available), 64'd0);

        wait_frame();
        check_dac("dac_extra_absent", '0);

        // clear and read in the same cycle with two entries stored
        wait_frame();
        check("two_entries", 64'(audio_in_available), 64'd1);
        clear_in = 1'b1;
        read_in  = 1'b1;
        @(negedge clk);
        clear_in = 1'b0;
        read_in  = 1'b0;
        check("clear_read_available", 64'(audio_in_available), 64'd0);
        check("clear_read_left",      64'(left_in), 64'd0);
        adc_q.push_back(r_bad);
        adc_q.push_back(r_good);

        // reset in the middle of a left slot
        wait_frame();
        for (int i = 0; i < DEPTH; i++) write_pair(p_vec[i]);
        check("pre_reset_full", 64'(audio_out_allowed), 64'd0);
        repeat (100) @(negedge clk);
        check("pre_reset_available", 64'(audio_in_available), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_available", 64'(audio_in_available), 64'd0);
        check("mid_rst_allowed",   64'(audio_out_allowed),  64'd1);
        check("mid_rst_left",      64'(left_in),  64'd0);
        check("mid_rst_right",     64'(right_in), 64'd0);
        check("mid_rst_dacdat",    64'(aud_dacdat), 64'd0);
        repeat (10) @(negedge clk);
        rst_n = 1'b1;

        wait_frame();
        check("partial_frame_dropped", 64'(audio_in_available), 64'd0);
        wait_frame();
        check("post_rst_available", 64'(audio_in_available), 64'd1);
        check("post_rst_left",      64'(left_in),  64'(r_good[2*W-1:W]));
        check("post_rst_right",     64'(right_in), 64'(r_good[W-1:0]));
        check_dac("dac_flushed_by_reset", '0);
        pulse_read();
        check("post_rst_drained", 64'(audio_in_available), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_controller.md
# audio_controller

Audio-codec streaming interface for the DE1-SoC WM8731 path. It deserializes ADC samples from the codec into an input FIFO and serializes samples from an output FIFO onto the DAC line. It also generates the codec master clock. It sits between user sample logic and the codec pins; register configuration over I2C is handled by the separate avconf block.

## Interface
Parameters:
- AUDIO_DATA_WIDTH, 32: bits per channel sample; serial slot length is the same.
- FIFO_DEPTH, 128: entries (left/right pairs) per FIFO; power of two, ≥2.

Ports:
- CLOCK_50  in  1  system clock; sole clock domain.
- reset  in  1  asynchronous, active-low reset.
- clear_audio_in_memory  in  1  synchronous flush of the input FIFO.
- read_audio_in  in  1  pop one pair from the input FIFO.
- clear_audio_out_memory  in  1  synchronous flush of the output FIFO.
- left_channel_audio_out  in  AUDIO_DATA_WIDTH  left sample to enqueue.
- right_channel_audio_out  in  AUDIO_DATA_WIDTH  right sample to enqueue.
- write_audio_out  in  1  push one pair into the output FIFO.
- AUD_ADCDAT  in  1  serial ADC data from the codec.
- AUD_BCLK  inout  1  codec bit clock; always driven Z, used as an input.
- AUD_ADCLRCK  inout  1  ADC frame clock; always driven Z, used as an input.
- AUD_DACLRCK  inout  1  DAC frame clock; always driven Z, used as an input.
- audio_in_available  out  1  input FIFO not empty.
- left_channel_audio_in  out  AUDIO_DATA_WIDTH  head-of-FIFO left sample (show-ahead).
- right_channel_audio_in  out  AUDIO_DATA_WIDTH  head-of-FIFO right sample (show-ahead).
- audio_out_allowed  out  1  output FIFO not full.
- AUD_XCK  out  1  codec master clock, CLOCK_50/4.
- AUD_DACDAT  out  1  serial DAC data.

## Operation
- Serial format: codec is master, left-justified, MSB first.
  - LRCK high = left slot; LRCK low = right slot.
  - ADC bits are sampled on BCLK rising edges; DAC bits change on BCLK falling edges.
- Synchronization: BCLK, ADCLRCK and DACLRCK each pass through a 2-flop synchronizer; edges are detected from the synchronized value.
- Capture path:
  - On each ADCLRCK edge, clear the bit counter and select the channel register.
  - Shift AUD_ADCDAT into that register on the first AUDIO_DATA_WIDTH BCLK rising edges of the slot; ignore further bits.
  - A frame is complete when the right slot has been captured. On the next ADCLRCK rising edge, push {left,right} into the input FIFO.
  - If the input FIFO is full, drop the new frame; stored data is unaffected.
  - Ignore any frame whose left slot began before reset released.
- Read side: read_audio_in pops when not empty and is ignored when empty. The show-ahead outputs are 0 when the FIFO is empty.
- Write side: write_audio_out pushes when not full and is ignored when full, even if a pop occurs in the same cycle.
- Playback path:
  - On a DACLRCK rising edge, pop one pair into the left/right shift registers. If the output FIFO is empty, load zeros (silence).
  - The left word is shifted during LRCK high; the right word is selected on the DACLRCK falling edge.
  - AUD_DACDAT presents the MSB immediately and advances one bit per BCLK falling edge. After AUDIO_DATA_WIDTH bits it outputs 0.
- Flushes: clear_* empties the FIFO (pointers and count to 0) and takes priority over a push or pop in the same cycle.
- FIFO arithmetic: pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. The count is one bit wider. A simultaneous push and pop when neither full nor empty leaves the count unchanged.
- AUD_XCK toggles every 2 CLOCK_50 cycles (12.5 MHz).

## Timing
- Reset state:
  - audio_in_available=0, audio_out_allowed=1.
  - left/right_channel_audio_in=0, AUD_DACDAT=0, AUD_XCK=0.
  - FIFOs empty; all shift registers and counters 0.
- Pin edge to internal edge-detect pulse: 3 CLOCK_50 cycles.
- BCLK must be ≤ CLOCK_50/8 (each half-period ≥4 cycles).
- Input FIFO push to audio_in_available=1: next cycle.
- Pop to audio_in_available/data update: next cycle.
- A write accepted in the cycle that fills the FIFO drops audio_out_allowed on the next cycle.
- A pop on a DACLRCK edge raises audio_out_allowed on the next cycle.
- Asserting reset mid-frame clears everything immediately (asynchronously); the partial frame is discarded.

## Test plan
- Reset held low 10 cycles → audio_in_available=0, audio_out_allowed=1, AUD_DACDAT=0, sample outputs 0; after release AUD_XCK period = 4 cycles.
- Codec model sends left=32'hA5A5_0001, right=32'h0000_FFFF, BCLK=CLOCK_50/8 → after the next ADCLRCK rise, audio_in_available=1 with matching outputs; one read_audio_in pulse → available=0 next cycle.
- Write 32'h8000_0001/32'h7FFF_FFFE → next DAC frame streams those bits MSB first, then zeros to slot end; with the output FIFO empty, AUD_DACDAT stays 0 for the whole frame.
- FIFO_DEPTH writes with no frames → audio_out_allowed=0; an extra write is ignored; subsequent frames play the writes in order.
- FIFO_DEPTH+1 ADC frames without reads → exactly FIFO_DEPTH pairs read back, oldest first; the last frame is absent.
- clear_audio_in_memory and read_audio_in in the same cycle → empty next cycle.
- Reset pulsed mid-left-slot → outputs reset at once; the next complete frame is captured correctly.
